// File: rtl/mtimer_io.sv
// Memory-mapped 64-bit machine timer with compare interrupt.
// Define MTIMER_PRESCALER_EN to build the 16-bit tick prescaler.
module mtimer_io #(
  parameter logic [7:0] BASE_ADDR = 8'h40
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic [7:0]  io_addr,
  input  logic        io_en,
  input  logic        io_we,
  input  logic [31:0] io_data_write,
  output logic [31:0] io_data_read,
  output logic        irq_mtimecmp
);

  localparam logic [2:0] OFF_MLO  = 3'd0;
  localparam logic [2:0] OFF_MHI  = 3'd1;
  localparam logic [2:0] OFF_CLO  = 3'd2;
  localparam logic [2:0] OFF_CHI  = 3'd3;
  localparam logic [2:0] OFF_CTRL = 3'd4;
  localparam logic [2:0] OFF_PSC  = 3'd5;

  logic        sel;
  logic        rd;
  logic        wr;
  logic [2:0]  off;

  logic        wr_mlo;
  logic        wr_mhi;
  logic        wr_clo;
  logic        wr_chi;
  logic        wr_ctrl;
  logic        rd_mlo;

  logic [1:0]  sync_q;
  logic        run;
  logic        tick;

  logic [63:0] mtime_q;
  logic [63:0] mtime_d;
  logic [31:0] shadow_q;
  logic [31:0] shadow_d;
  logic [63:0] cmp_q;
  logic [63:0] cmp_d;
  logic        en_q;
  logic        en_d;
  logic        irq_q;
  logic        irq_d;

  logic [31:0] psc_rd;
  logic [31:0] rdata;

  logic        unused_addr;

  assign unused_addr = ^io_addr[1:0];

  assign sel = io_en && (io_addr[7:5] == BASE_ADDR[7:5]);
  assign off = io_addr[4:2];
  assign rd  = sel && !io_we;
  assign wr  = sel && io_we;

  assign wr_mlo  = wr && (off == OFF_MLO);
  assign wr_mhi  = wr && (off == OFF_MHI);
  assign wr_clo  = wr && (off == OFF_CLO);
  assign wr_chi  = wr && (off == OFF_CHI);
  assign wr_ctrl = wr && (off == OFF_CTRL);
  assign rd_mlo  = rd && (off == OFF_MLO);

  // Counting starts only after reset release has passed two flops.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign run = sync_q[1];

`ifdef MTIMER_PRESCALER_EN
  logic        wr_psc;
  logic [15:0] presc_q;
  logic [15:0] presc_d;
  logic [15:0] pcnt_q;
  logic [15:0] pcnt_d;

  assign wr_psc = wr && (off == OFF_PSC);

  always_comb begin
    presc_d = presc_q;
    pcnt_d  = pcnt_q;
    if (wr_psc) begin
      presc_d = io_data_write[15:0];
      pcnt_d  = io_data_write[15:0];
    end else if (en_q && run) begin
      if (pcnt_q == 16'd0) begin
        pcnt_d = presc_q;
      end else begin
        pcnt_d = pcnt_q - 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      presc_q <= 16'd0;
      pcnt_q  <= 16'd0;
    end else begin
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign tick   = en_q && run && (pcnt_q == 16'd0);
  assign psc_rd = {16'd0, presc_q};
`else
  assign tick   = en_q && run;
  assign psc_rd = 32'd0;
`endif

  // A write to one half wins and leaves the other half untouched.
  always_comb begin
    mtime_d = mtime_q;
    if (wr_mlo) begin
      mtime_d[31:0] = io_data_write;
    end else if (wr_mhi) begin
      mtime_d[63:32] = io_data_write;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    if (rd_mlo) begin
      shadow_d = mtime_q[63:32];
    end
  end

  always_comb begin
    cmp_d = cmp_q;
    if (wr_clo) begin
      cmp_d[31:0] = io_data_write;
    end
    if (wr_chi) begin
      cmp_d[63:32] = io_data_write;
    end
  end

  assign en_d  = wr_ctrl ? io_data_write[0] : en_q;
  assign irq_d = (mtime_q >= cmp_q);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      mtime_q  <= 64'd0;
      shadow_q <= 32'd0;
      cmp_q    <= 64'hFFFF_FFFF_FFFF_FFFF;
      en_q     <= 1'b1;
      irq_q    <= 1'b0;
    end else begin
      mtime_q  <= mtime_d;
      shadow_q <= shadow_d;
      cmp_q    <= cmp_d;
      en_q     <= en_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (rd && resetb) begin
      case (off)
        OFF_MLO:  rdata = mtime_q[31:0];
        OFF_MHI:  rdata = shadow_q;
        OFF_CLO:  rdata = cmp_q[31:0];
        OFF_CHI:  rdata = cmp_q[63:32];
        OFF_CTRL: rdata = {30'd0, irq_q, en_q};
        OFF_PSC:  rdata = psc_rd;
        default:  rdata = 32'd0;
      endcase
    end
  end

  assign io_data_read = rdata;
  assign irq_mtimecmp = irq_q;

endmodule

// File: tb/tb_mtimer_io.sv
// Self-checking bench for mtimer_io.
// Honours MTIMER_PRESCALER_EN when defined.
module tb_mtimer_io;

  localparam logic [7:0] BASE = 8'h40;

  logic        clk;
  logic        resetb;
  logic [7:0]  io_addr;
  logic        io_en;
  logic        io_we;
  logic [31:0] io_data_write;
  logic [31:0] io_data_read;
  logic        irq_mtimecmp;

  int nchk;
  int nfail;

  mtimer_io #(.BASE_ADDR(BASE)) dut (
    .clk           (clk),
    .resetb        (resetb),
    .io_addr       (io_addr),
    .io_en         (io_en),
    .io_we         (io_we),
    .io_data_write (io_data_write),
    .io_data_read  (io_data_read),
    .irq_mtimecmp  (irq_mtimecmp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] reg_addr(input logic [2:0] off);
    return BASE | {3'b000, off, 2'b00};
  endfunction

  task automatic acc_write(input logic [2:0] off, input logic [31:0] d);
    io_en = 1'b1;
    io_we = 1'b1;
    io_addr = reg_addr(off);
    io_data_write = d;
    @(negedge clk);
    io_en = 1'b0;
    io_we = 1'b0;
  endtask

  task automatic acc_read(input logic [2:0] off, output logic [31:0] d);
    io_en = 1'b1;
    io_we = 1'b0;
    io_addr = reg_addr(off);
    #1;
    d = io_data_read;
    @(negedge clk);
    io_en = 1'b0;
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    @(negedge clk);
    io_en = 1'b1;
    io_we = 1'b0;
    io_addr = reg_addr(3'd2);
    #1;
    nchk++;
    if (io_data_read !== 32'd0) begin
      nfail++;
      $display("FAIL rst_rdata got %h want 0", io_data_read);
    end
    nchk++;
    if (irq_mtimecmp !== 1'b0) begin
      nfail++;
      $display("FAIL rst_irq got %b want 0", irq_mtimecmp);
    end
    @(negedge clk);
    io_en = 1'b0;
  endtask

  task automatic test_count();
    logic [31:0] v;
    resetb = 1'b1;
    repeat (100) @(negedge clk);
    acc_read(3'd0, v);
    nchk++;
    if (v < 32'd97 || v > 32'd99) begin
      nfail++;
      $display("FAIL count_lo got %0d want 98+/-1", v);
    end
    acc_read(3'd1, v);
    nchk++;
    if (v !== 32'd0) begin
      nfail++;
      $display("FAIL count_hi got %h want 0", v);
    end
    acc_read(3'd2, v);
    nchk++;
    if (v !== 32'hFFFF_FFFF) begin
      nfail++;
      $display("FAIL rst_cmplo got %h want ffffffff", v);
    end
    acc_read(3'd3, v);
    nchk++;
    if (v !== 32'hFFFF_FFFF) begin
      nfail++;
      $display("FAIL rst_cmphi got %h want ffffffff", v);
    end
    acc_read(3'd4, v);
    nchk++;
    if (v !== 32'd1) begin
      nfail++;
      $display("FAIL rst_ctrl got %h want 1", v);
    end
    acc_read(3'd5, v);
    nchk++;
    if (v !== 32'd0) begin
      nfail++;
      $display("FAIL rst_psc got %h want 0", v);
    end
  endtask

  task automatic test_carry();
    logic [31:0] lo;
    logic [31:0] hi;
    acc_write(3'd1, 32'd0);
    acc_write(3'd0, 32'hFFFF_FFFE);
    @(negedge clk);
    acc_read(3'd0, lo);
    acc_read(3'd1, hi);
    nchk++;
    if ({hi, lo} !== 64'h0000_0000_FFFF_FFFF) begin
      nfail++;
      $display("FAIL carry_pair got %h_%h want 0_ffffffff", hi, lo);
    end
    acc_read(3'd0, lo);
    acc_read(3'd1, hi);
    nchk++;
    if ({hi, lo} !== 64'h0000_0001_0000_0001) begin
      nfail++;
      $display("FAIL carry_next got %h_%h want 1_00000001", hi, lo);
    end
  endtask

  task automatic test_irq();
    logic [31:0] v;
    acc_write(3'd3, 32'd0);
    acc_write(3'd2, 32'd50);
    acc_write(3'd0, 32'd0);
    acc_write(3'd1, 32'd0);
    repeat (50) @(negedge clk);
    nchk++;
    if (irq_mtimecmp !== 1'b0) begin
      nfail++;
      $display("FAIL irq_early got %b want 0", irq_mtimecmp);
    end
    @(negedge clk);
    nchk++;
    if (irq_mtimecmp !== 1'b1) begin
      nfail++;
      $display("FAIL irq_rise got %b want 1", irq_mtimecmp);
    end
    acc_read(3'd0, v);
    nchk++;
    if (v !== 32'd51) begin
      nfail++;
      $display("FAIL irq_mtime got %0d want 51", v);
    end
    acc_write(3'd2, 32'd1000);
    nchk++;
    if (irq_mtimecmp !== 1'b1) begin
      nfail++;
      $display("FAIL irq_hold got %b want 1", irq_mtimecmp);
    end
    @(negedge clk);
    nchk++;
    if (irq_mtimecmp !== 1'b0) begin
      nfail++;
      $display("FAIL irq_fall got %b want 0", irq_mtimecmp);
    end
  endtask

  task automatic test_disable();
    logic [31:0] a;
    logic [31:0] b;
    acc_write(3'd4, 32'd0);
    acc_read(3'd0, a);
    repeat (20) @(negedge clk);
    acc_read(3'd0, b);
    nchk++;
    if (a !== 32'd55 || b !== 32'd55) begin
      nfail++;
      $display("FAIL dis_freeze got %0d,%0d want 55,55", a, b);
    end
    acc_write(3'd2, 32'd0);
    @(negedge clk);
    acc_read(3'd4, a);
    nchk++;
    if (a !== 32'd2 || irq_mtimecmp !== 1'b1) begin
      nfail++;
      $display("FAIL dis_ctrl got %h irq %b want 2 irq 1", a, irq_mtimecmp);
    end
    acc_write(3'd2, 32'hFFFF_FFFF);
    acc_write(3'd3, 32'hFFFF_FFFF);
    acc_write(3'd4, 32'd3);
    acc_read(3'd4, a);
    nchk++;
    if (a !== 32'd1) begin
      nfail++;
      $display("FAIL dis_reen got %h want 1", a);
    end
  endtask

  task automatic test_prescale();
    logic [31:0] v;
`ifdef MTIMER_PRESCALER_EN
    acc_write(3'd5, 32'd3);
    acc_write(3'd0, 32'd0);
    repeat (40) @(negedge clk);
    acc_read(3'd0, v);
    nchk++;
    if (v < 32'd9 || v > 32'd11) begin
      nfail++;
      $display("FAIL psc_count got %0d want 10+/-1", v);
    end
    acc_write(3'd5, 32'hFFFF_0007);
    acc_read(3'd5, v);
    nchk++;
    if (v !== 32'd7) begin
      nfail++;
      $display("FAIL psc_read got %h want 7", v);
    end
    acc_write(3'd5, 32'd0);
`else
    acc_write(3'd5, 32'd3);
    acc_read(3'd5, v);
    nchk++;
    if (v !== 32'd0) begin
      nfail++;
      $display("FAIL psc_read got %h want 0", v);
    end
`endif
  endtask

  task automatic test_decode();
    logic [31:0] v;
    io_en = 1'b1;
    io_we = 1'b0;
    io_addr = BASE + 8'h20;
    #1;
    nchk++;
    if (io_data_read !== 32'd0) begin
      nfail++;
      $display("FAIL dec_outside got %h want 0", io_data_read);
    end
    @(negedge clk);
    io_en = 1'b0;
    acc_read(3'd6, v);
    nchk++;
    if (v !== 32'd0) begin
      nfail++;
      $display("FAIL dec_resv got %h want 0", v);
    end
    io_en = 1'b1;
    io_we = 1'b1;
    io_addr = reg_addr(3'd3);
    io_data_write = 32'hFFFF_FFFF;
    #1;
    nchk++;
    if (io_data_read !== 32'd0) begin
      nfail++;
      $display("FAIL dec_wr_rdata got %h want 0", io_data_read);
    end
    @(negedge clk);
    io_en = 1'b0;
    io_we = 1'b0;
    acc_write(3'd2, 32'd0);
    acc_write(3'd3, 32'd0);
    @(negedge clk);
    #2;
    resetb = 1'b0;
    io_en = 1'b1;
    io_addr = reg_addr(3'd2);
    #1;
    nchk++;
    if (irq_mtimecmp !== 1'b0 || io_data_read !== 32'd0) begin
      nfail++;
      $display("FAIL dec_async_rst irq %b rd %h want 0 0",
               irq_mtimecmp, io_data_read);
    end
    @(negedge clk);
    io_en = 1'b0;
    resetb = 1'b1;
    acc_read(3'd0, v);
    nchk++;
    if (v !== 32'd0) begin
      nfail++;
      $display("FAIL dec_rst_mtime got %h want 0", v);
    end
    acc_read(3'd3, v);
    nchk++;
    if (v !== 32'hFFFF_FFFF) begin
      nfail++;
      $display("FAIL dec_rst_cmp got %h want ffffffff", v);
    end
  endtask

  task automatic test_random();
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic [31:0] m_shadow;
    logic        m_en;
    logic        m_irq;
    logic [31:0] exp_rd;
    logic [31:0] d;
    logic [2:0]  off;
    logic        n_irq;
    int          op;
    acc_write(3'd0, 32'hFFFF_FFF0);
    acc_write(3'd1, 32'hFFFF_FFFF);
    acc_write(3'd2, 32'hFFFF_FFF8);
    acc_write(3'd3, 32'hFFFF_FFFF);
    m_mtime  = 64'hFFFF_FFFF_FFFF_FFF2;
    m_cmp    = 64'hFFFF_FFFF_FFFF_FFF8;
    m_shadow = 32'd0;
    m_en     = 1'b1;
    m_irq    = 1'b0;
    for (int i = 0; i < 300; i++) begin
      op = (i < 16) ? 6 : int'($urandom_range(0, 10));
      d = $urandom;
      off = 3'($urandom_range(0, 7));
      io_en = 1'b0;
      io_we = 1'b0;
      case (op)
        0: begin off = 3'd0; d = (d[0]) ? 32'($urandom_range(0, 300)) : d; end
        1: begin off = 3'd1; d = 32'($urandom_range(0, 1)); end
        2: begin off = 3'd2; d = 32'($urandom_range(0, 400)); end
        3: begin off = 3'd3; d = 32'($urandom_range(0, 1)); end
        4: off = 3'd4;
        6: off = 3'd0;
        7: off = 3'd1;
        default: ;
      endcase
      io_data_write = d;
      io_addr = reg_addr(off) | 8'($urandom_range(0, 3));
      if (op <= 4) begin
        io_en = 1'b1;
        io_we = 1'b1;
      end else if (op <= 7) begin
        io_en = 1'b1;
      end else if (op == 10) begin
        io_en = 1'b1;
        io_we = 1'b1;
        io_addr = {3'($urandom_range(3, 7)), 5'($urandom)};
      end
      exp_rd = 32'd0;
      if (op >= 5 && op <= 7) begin
        case (off)
          3'd0: exp_rd = m_mtime[31:0];
          3'd1: exp_rd = m_shadow;
          3'd2: exp_rd = m_cmp[31:0];
          3'd3: exp_rd = m_cmp[63:32];
          3'd4: exp_rd = {30'd0, m_irq, m_en};
          default: exp_rd = 32'd0;
        endcase
      end
      #1;
      nchk++;
      if (io_data_read !== exp_rd) begin
        nfail++;
        $display("FAIL rnd_rdata i=%0d op=%0d got %h want %h",
                 i, op, io_data_read, exp_rd);
      end
      nchk++;
      if (irq_mtimecmp !== m_irq) begin
        nfail++;
        $display("FAIL rnd_irq i=%0d got %b want %b", i, irq_mtimecmp, m_irq);
      end
      n_irq = (m_mtime >= m_cmp);
      if (op >= 5 && op <= 7 && off == 3'd0) m_shadow = m_mtime[63:32];
      if (op == 0) m_mtime[31:0] = d;
      else if (op == 1) m_mtime[63:32] = d;
      else if (m_en) m_mtime = m_mtime + 64'd1;
      if (op == 2) m_cmp[31:0] = d;
      if (op == 3) m_cmp[63:32] = d;
      if (op == 4) m_en = d[0];
      m_irq = n_irq;
      @(negedge clk);
    end
    io_en = 1'b0;
    io_we = 1'b0;
  endtask

  initial begin
    nchk = 0;
    nfail = 0;
    resetb = 1'b0;
    io_en = 1'b0;
    io_we = 1'b0;
    io_addr = 8'd0;
    io_data_write = 32'd0;
    test_reset();
    test_count();
    test_carry();
    test_irq();
    test_disable();
    test_prescale();
    test_decode();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
